// File: rtl/execute_store_bus_if.sv
// Data-memory write bus between the store unit (master) and the memory (slave).
interface execute_store_bus_if;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_wvalid;
   logic        mem_wready;
   logic        mem_bresp_valid;
   logic        mem_bresp_err;

   modport master (
      output mem_addr, mem_wdata, mem_wstrb, mem_wvalid,
      input  mem_wready, mem_bresp_valid, mem_bresp_err
   );

   modport slave (
      input  mem_addr, mem_wdata, mem_wstrb, mem_wvalid,
      output mem_wready, mem_bresp_valid, mem_bresp_err
   );
endinterface

// File: rtl/execute_store_bus.sv
// Store path to the data-memory bus: takes one resolved store, checks
// alignment, steers lanes/strobes, runs a single-outstanding write with a
// response timeout and reports done/error for one cycle.
module execute_store_bus #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned TIMEOUT_W      = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic [31:0]                req_addr,
   input  logic [31:0]                req_val,
   input  logic [1:0]                 req_size,
   execute_store_bus_if.master        mem,
   output logic                       store_done,
   output logic                       store_error,
   output logic [1:0]                 error_cause,
   output logic                       busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMD  = 2'd1,
      RESP = 2'd2,
      FIN  = 2'd3
   } state_t;

   localparam logic [TIMEOUT_W-1:0] CNT_ZERO = {TIMEOUT_W{1'b0}};
   localparam logic [TIMEOUT_W-1:0] CNT_ONE  = TIMEOUT_W'(1);
   localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

   // Size 11, odd halfword or unaligned word never reach the bus.
   function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] addr_lo);
      logic bad;
      case (size)
         2'b00:   bad = 1'b0;
         2'b01:   bad = addr_lo[0];
         2'b10:   bad = (addr_lo != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

   // Replicate the right-justified value into every lane it may occupy.
   function automatic logic [31:0] steer_wdata(input logic [1:0] size, input logic [31:0] val);
      logic [31:0] d;
      case (size)
         2'b00:   d = {4{val[7:0]}};
         2'b01:   d = {2{val[15:0]}};
         default: d = val;
      endcase
      return d;
   endfunction

   function automatic logic [3:0] steer_wstrb(input logic [1:0] size, input logic [1:0] addr_lo);
      logic [3:0] s;
      case (size)
         2'b00:   s = 4'b0001 << addr_lo;
         2'b01:   s = addr_lo[1] ? 4'b1100 : 4'b0011;
         2'b10:   s = 4'b1111;
         default: s = 4'b0000;
      endcase
      return s;
   endfunction

   state_t               state_r, state_nxt_s;
   logic [TIMEOUT_W-1:0] cnt_r, cnt_nxt_s;
   logic [31:0]          addr_r, wdata_r;
   logic [3:0]           wstrb_r;
   logic [1:0]           cause_r, cause_nxt_s;
   logic                 ready_r, ready_nxt_s;
   logic                 wvalid_r, wvalid_nxt_s;
   logic                 busy_r, busy_nxt_s;
   logic                 done_r, done_nxt_s;
   logic                 error_r, error_nxt_s;
   logic                 accept_s, illegal_s, cmd_fire_s, timeout_hit_s;

   assign accept_s      = (state_r == IDLE) && req_valid;
   assign illegal_s     = is_illegal(req_size, req_addr[1:0]);
   assign cmd_fire_s    = (state_r == CMD) && mem.mem_wready;
   assign timeout_hit_s = (cnt_r == CNT_LAST);

   // State register; reset abandons any transaction in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state decision.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               state_nxt_s = illegal_s ? FIN : CMD;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         CMD: begin
            if (mem.mem_wready) begin
               // A response arriving with the accept closes the store at once.
               state_nxt_s = mem.mem_bresp_valid ? FIN : RESP;
            end else begin
               state_nxt_s = CMD;
            end
         end
         RESP: begin
            if (mem.mem_bresp_valid || timeout_hit_s) begin
               state_nxt_s = FIN;
            end else begin
               state_nxt_s = RESP;
            end
         end
         FIN:     state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // Next values of the registered outputs, counter and cause.
   always_comb begin
      done_nxt_s  = 1'b0;
      error_nxt_s = 1'b0;
      cause_nxt_s = cause_r;
      cnt_nxt_s   = cnt_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               error_nxt_s = illegal_s;
               cause_nxt_s = illegal_s ? 2'b01 : 2'b00;
            end else begin
               error_nxt_s = 1'b0;
            end
         end
         CMD: begin
            if (cmd_fire_s) begin
               cnt_nxt_s = CNT_ZERO;
               if (mem.mem_bresp_valid) begin
                  done_nxt_s  = ~mem.mem_bresp_err;
                  error_nxt_s = mem.mem_bresp_err;
                  cause_nxt_s = mem.mem_bresp_err ? 2'b10 : 2'b00;
               end else begin
                  done_nxt_s = 1'b0;
               end
            end else begin
               cnt_nxt_s = cnt_r;
            end
         end
         RESP: begin
            cnt_nxt_s = cnt_r + CNT_ONE;
            // The response takes priority over a coincident timeout.
            if (mem.mem_bresp_valid) begin
               done_nxt_s  = ~mem.mem_bresp_err;
               error_nxt_s = mem.mem_bresp_err;
               cause_nxt_s = mem.mem_bresp_err ? 2'b10 : 2'b00;
            end else if (timeout_hit_s) begin
               error_nxt_s = 1'b1;
               cause_nxt_s = 2'b11;
            end else begin
               done_nxt_s = 1'b0;
            end
         end
         FIN:     cnt_nxt_s = cnt_r;
         default: cnt_nxt_s = cnt_r;
      endcase
      ready_nxt_s  = (state_nxt_s == IDLE);
      wvalid_nxt_s = (state_nxt_s == CMD);
      busy_nxt_s   = (state_nxt_s != IDLE);
   end

   // Output and datapath registers; bus fields are captured once at accept.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ready_r  <= 1'b1;
         wvalid_r <= 1'b0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         error_r  <= 1'b0;
         cause_r  <= 2'b00;
         cnt_r    <= CNT_ZERO;
         addr_r   <= 32'h0000_0000;
         wdata_r  <= 32'h0000_0000;
         wstrb_r  <= 4'b0000;
      end else begin
         ready_r  <= ready_nxt_s;
         wvalid_r <= wvalid_nxt_s;
         busy_r   <= busy_nxt_s;
         done_r   <= done_nxt_s;
         error_r  <= error_nxt_s;
         cause_r  <= cause_nxt_s;
         cnt_r    <= cnt_nxt_s;
         if (accept_s) begin
            addr_r  <= {req_addr[31:2], 2'b00};
            wdata_r <= steer_wdata(req_size, req_val);
            wstrb_r <= steer_wstrb(req_size, req_addr[1:0]);
         end
      end
   end

   assign req_ready      = ready_r;
   assign busy           = busy_r;
   assign store_done     = done_r;
   assign store_error    = error_r;
   assign error_cause    = cause_r;
   assign mem.mem_addr   = addr_r;
   assign mem.mem_wdata  = wdata_r;
   assign mem.mem_wstrb  = wstrb_r;
   assign mem.mem_wvalid = wvalid_r;

endmodule

// File: tb/tb_execute_store_bus.sv
// Bench for execute_store_bus: a transaction-level model predicts, for each
// store, the cycle-by-cycle port values from its accept point, wait states
// and response choice; one negedge process compares every cycle.
module tb_execute_store_bus;
   localparam int T = 255;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready;
   logic [31:0] req_addr, req_val;
   logic [1:0]  req_size;
   logic        store_done, store_error, busy;
   logic [1:0]  error_cause;

   execute_store_bus_if mem_if();

   execute_store_bus #(.TIMEOUT_CYCLES(T), .TIMEOUT_W(8)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_val(req_val), .req_size(req_size),
      .mem(mem_if),
      .store_done(store_done), .store_error(store_error),
      .error_cause(error_cause), .busy(busy)
   );

   always #5 clk = ~clk;

   // model expectations for the current cycle
   logic        exp_ready, exp_busy, exp_wvalid, exp_done, exp_err;
   logic [1:0]  exp_cause;
   logic [31:0] exp_addr, exp_wdata;
   logic [3:0]  exp_wstrb;
   bit          bus_known, chk_en;
   int          total = 0, bad = 0, cyc = 0, wv_cnt = 0, pulse_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("req_ready",   32'(req_ready),          32'(exp_ready));
         check("busy",        32'(busy),               32'(exp_busy));
         check("mem_wvalid",  32'(mem_if.mem_wvalid),  32'(exp_wvalid));
         check("store_done",  32'(store_done),         32'(exp_done));
         check("store_error", 32'(store_error),        32'(exp_err));
         check("error_cause", 32'(error_cause),        32'(exp_cause));
         check("mem_addr",    mem_if.mem_addr,         exp_addr);
         if (bus_known) begin
            check("mem_wdata", mem_if.mem_wdata,       exp_wdata);
            check("mem_wstrb", 32'(mem_if.mem_wstrb),  32'(exp_wstrb));
         end
      end
      if (mem_if.mem_wvalid === 1'b1) wv_cnt++;
      if (store_done === 1'b1 || store_error === 1'b1) pulse_cnt++;
   end

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic set_idle();
      exp_ready = 1'b1; exp_busy = 1'b0; exp_wvalid = 1'b0;
      exp_done = 1'b0;  exp_err = 1'b0;
   endtask

   // Bus inputs that a correct unit must ignore outside CMD/RESP.
   task automatic drive_noise();
      mem_if.mem_wready      = 1'($urandom_range(0, 1));
      mem_if.mem_bresp_valid = ($urandom_range(0, 3) == 0);
      mem_if.mem_bresp_err   = 1'($urandom_range(0, 1));
   endtask

   // One store. Called in an idle cycle. w = cycles of wready stall,
   // b = 0: response with the command accept, b > 0: response in the b-th
   // response-wait cycle, b < 0: never. rst_at >= 0 resets in that wait cycle.
   // lat = cycles from the first busy cycle to the done/error pulse.
   task automatic run_store(input logic [31:0] addr, input logic [31:0] val,
                            input logic [1:0] size, input int w, input int b,
                            input logic berr, input bit hold, input int rst_at,
                            output int lat);
      logic illegal;
      int   nb, m, a, nresp;
      illegal = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
                (size == 2'b10 && addr[1:0] != 2'b00);
      lat = -1;
      req_valid = 1'b1; req_addr = addr; req_val = val; req_size = size;
      drive_noise();
      step();
      a = cyc;
      if (!hold) begin
         req_valid = 1'($urandom_range(0, 1));
         req_addr = $urandom; req_val = $urandom; req_size = 2'($urandom_range(0, 3));
      end
      exp_addr = {addr[31:2], 2'b00};
      exp_ready = 1'b0; exp_busy = 1'b1; exp_done = 1'b0; exp_err = 1'b0;
      if (illegal) begin
         bus_known = 1'b0; exp_cause = 2'b01; exp_err = 1'b1; exp_wvalid = 1'b0;
         lat = 0;
         drive_noise();
         step();
         set_idle();
      end else begin
         nb = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
         m = ((1 << nb) - 1) << addr[1:0];
         exp_wstrb = 4'(m);
         case (size)
            2'b00:   exp_wdata = 32'(val[7:0]) * 32'h0101_0101;
            2'b01:   exp_wdata = 32'(val[15:0]) * 32'h0001_0001;
            default: exp_wdata = val;
         endcase
         bus_known = 1'b1; exp_cause = 2'b00; exp_wvalid = 1'b1;
         for (int k = 0; k <= w; k++) begin
            if (k == w) begin
               mem_if.mem_wready      = 1'b1;
               mem_if.mem_bresp_valid = (b == 0);
               mem_if.mem_bresp_err   = berr;
            end else begin
               mem_if.mem_wready      = 1'b0;
               mem_if.mem_bresp_valid = 1'($urandom_range(0, 1));
               mem_if.mem_bresp_err   = 1'($urandom_range(0, 1));
            end
            step();
         end
         exp_wvalid = 1'b0;
         if (b != 0) begin
            nresp = (b < 0) ? T : b;
            for (int j = 0; j < nresp; j++) begin
               if (rst_at == j) begin
                  #2;
                  reset = 1'b1;
                  set_idle();
                  exp_cause = 2'b00; exp_addr = 32'h0; exp_wdata = 32'h0;
                  exp_wstrb = 4'h0; bus_known = 1'b1;
                  mem_if.mem_wready = 1'b0; mem_if.mem_bresp_valid = 1'b0;
                  req_valid = 1'b0;
                  #1;
                  check("async_rst_busy", 32'(busy), 32'd0);
                  check("async_rst_wdata", mem_if.mem_wdata, 32'h0);
                  step();
                  step();
                  reset = 1'b0;
                  step();
                  return;
               end
               mem_if.mem_wready      = 1'($urandom_range(0, 1));
               mem_if.mem_bresp_valid = (b > 0 && j == b - 1);
               mem_if.mem_bresp_err   = berr;
               step();
            end
         end
         if (b < 0) begin
            exp_err = 1'b1; exp_cause = 2'b11;
         end else if (berr) begin
            exp_err = 1'b1; exp_cause = 2'b10;
         end else begin
            exp_done = 1'b1;
         end
         lat = cyc - a;
         mem_if.mem_bresp_valid = 1'b0;
         step();
         set_idle();
      end
      req_valid = 1'b0;
      drive_noise();
   endtask

   initial begin
      int lat, wv0, p0;
      reset = 1'b1; chk_en = 1'b0;
      req_valid = 1'b0; req_addr = 32'h0; req_val = 32'h0; req_size = 2'b00;
      mem_if.mem_wready = 1'b0; mem_if.mem_bresp_valid = 1'b0; mem_if.mem_bresp_err = 1'b0;
      set_idle();
      exp_cause = 2'b00; exp_addr = 32'h0; exp_wdata = 32'h0; exp_wstrb = 4'h0;
      bus_known = 1'b1;
      step();
      chk_en = 1'b1;
      check("reset_ready", 32'(req_ready), 32'd1);
      step();
      reset = 1'b0;
      step();

      // byte store, zero-wait bus: done three cycles after the request cycle
      p0 = pulse_cnt;
      run_store(32'h0000_1003, 32'h0000_00AB, 2'b00, 0, 1, 1'b0, 1'b0, -1, lat);
      check("sb_latency", 32'(lat), 32'd2);
      check("sb_wdata", mem_if.mem_wdata, 32'hABAB_ABAB);
      check("sb_wstrb", 32'(mem_if.mem_wstrb), 32'h8);
      check("sb_addr", mem_if.mem_addr, 32'h0000_1000);
      check("sb_pulses", 32'(pulse_cnt - p0), 32'd1);

      // halfword with five stall cycles: wvalid for six cycles, one done
      wv0 = wv_cnt; p0 = pulse_cnt;
      run_store(32'h0000_2002, 32'h0000_1234, 2'b01, 5, 1, 1'b0, 1'b0, -1, lat);
      check("sh_wvalid_cycles", 32'(wv_cnt - wv0), 32'd6);
      check("sh_wdata", mem_if.mem_wdata, 32'h1234_1234);
      check("sh_wstrb", 32'(mem_if.mem_wstrb), 32'hC);
      check("sh_pulses", 32'(pulse_cnt - p0), 32'd1);

      // misaligned word: immediate error, no bus access
      wv0 = wv_cnt;
      run_store(32'h0000_3001, 32'hDEAD_BEEF, 2'b10, 0, 1, 1'b0, 1'b0, -1, lat);
      check("sw_mis_latency", 32'(lat), 32'd0);
      check("sw_mis_cause", 32'(error_cause), 32'd1);
      check("sw_mis_wvalid", 32'(wv_cnt - wv0), 32'd0);
      run_store(32'h0000_3000, 32'h1, 2'b11, 0, 1, 1'b0, 1'b0, -1, lat);
      run_store(32'h0000_3005, 32'h1, 2'b01, 0, 1, 1'b0, 1'b0, -1, lat);

      // bus error, then timeout, then a response on the last allowed cycle
      run_store(32'h0000_4000, 32'h5555_AAAA, 2'b10, 0, 2, 1'b1, 1'b0, -1, lat);
      check("berr_cause", 32'(error_cause), 32'd2);
      run_store(32'h0000_4000, 32'h1357_9BDF, 2'b10, 0, -1, 1'b0, 1'b0, -1, lat);
      check("timeout_cause", 32'(error_cause), 32'd3);
      check("timeout_latency", 32'(lat), 32'(T + 1));
      run_store(32'h0000_4004, 32'h2468_ACE0, 2'b10, 0, T, 1'b0, 1'b0, -1, lat);
      check("last_cycle_resp_cause", 32'(error_cause), 32'd0);

      // command accept and response in the same cycle
      run_store(32'h0000_6000, 32'hCAFE_F00D, 2'b10, 2, 0, 1'b0, 1'b0, -1, lat);
      check("same_cycle_latency", 32'(lat), 32'd3);

      // reset while waiting for the response, then a clean store
      p0 = pulse_cnt;
      run_store(32'h0000_7000, 32'h1111_2222, 2'b10, 0, -1, 1'b0, 1'b0, 3, lat);
      check("rst_no_pulse", 32'(pulse_cnt - p0), 32'd0);
      run_store(32'h0000_7004, 32'h3333_4444, 2'b10, 0, 1, 1'b0, 1'b0, -1, lat);
      check("after_rst_latency", 32'(lat), 32'd2);

      // back-to-back with req_valid held through busy
      run_store(32'h0000_8000, 32'h0000_00EE, 2'b00, 1, 2, 1'b0, 1'b1, -1, lat);
      run_store(32'h0000_8002, 32'h0000_BEEF, 2'b01, 0, 1, 1'b0, 1'b1, -1, lat);

      // randomized stores
      for (int i = 0; i < 150; i++) begin
         logic [1:0] sz;
         logic [31:0] ad;
         sz = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         ad = $urandom;
         if ($urandom_range(0, 3) != 0) begin
            if (sz == 2'b10) ad[1:0] = 2'b00;
            if (sz == 2'b01) ad[0] = 1'b0;
         end
         run_store(ad, $urandom, sz, $urandom_range(0, 3), $urandom_range(0, 4),
                   ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), -1, lat);
      end
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
